// File: rtl/lampfpu_sqrt_issue.sv
// -----------------------------------------------------------------------------
// lampfpu_sqrt_issue
// Request-side controller for the LAMP FPU sqrt / inverse-sqrt core.
// It accepts a packed 1-8-7 operand over a valid/ready handshake, then
// unpacks and classifies it. It holds the operand on the core interface with
// doSqrt_o high until the core raises valid_i, and returns the repacked result
// over a second valid/ready handshake. A watchdog aborts a core that stays
// silent for TIMEOUT_CYC cycles and returns 0x7FC0 with res_err_o set.
//
// Optional feature macro: LAMP_SQRT_ISSUE_BYPASS_EN
//   When defined, special operands (NaN, negative nonzero, +/-0, +inf) are
//   resolved locally and go straight to the response state. The core never
//   sees these operands.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-low reset
//   op_valid_i/op_ready_o    request handshake
//   op_i, op_inv_i           packed operand {s,e,f}; 1 = 1/sqrt, 0 = sqrt
//   doSqrt_o, invSqrt_o      core start (level) and mode
//   signum/extExp/extMant    unpacked operand to the core
//   isZero/isInf/isSNAN/isQNAN_op_o  operand class flags
//   valid_i, s/e/f_res_i     core result
//   res_valid_o/res_ready_i  result handshake
//   res_o, res_err_o         packed result, watchdog-abort flag
//   busy_o                   controller not idle
// -----------------------------------------------------------------------------
module lampfpu_sqrt_issue #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid_i,
  output logic        op_ready_o,
  input  logic [15:0] op_i,
  input  logic        op_inv_i,
  output logic        doSqrt_o,
  output logic        invSqrt_o,
  output logic        signum_op_o,
  output logic [7:0]  extExp_op_o,
  output logic [7:0]  extMant_op_o,
  output logic        isZero_op_o,
  output logic        isInf_op_o,
  output logic        isSNAN_op_o,
  output logic        isQNAN_op_o,
  input  logic        valid_i,
  input  logic        s_res_i,
  input  logic [7:0]  e_res_i,
  input  logic [6:0]  f_res_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [15:0] res_o,
  output logic        res_err_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CORE = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [7:0]  WD_LAST = 8'(TIMEOUT_CYC - 32'd1);
  localparam logic [15:0] QNAN_RES = 16'h7FC0;

  // Operand class as {zero, inf, snan, qnan}; bit 6 of the fraction is the quiet bit.
  function automatic logic [3:0] classify(input logic [7:0] e, input logic [6:0] f);
    logic e_zero;
    logic e_max;
    logic f_zero;
    e_zero = (e == 8'h00);
    e_max  = (e == 8'hFF);
    f_zero = (f == 7'h00);
    classify = {e_zero & f_zero, e_max & f_zero, e_max & ~f[6] & ~f_zero, e_max & f[6]};
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_wd;
  logic        r_inv;
  logic        r_sign;
  logic [7:0]  r_ext_exp;
  logic [7:0]  r_ext_mant;
  logic [3:0]  r_class;
  logic [15:0] r_res;
  logic        r_err;

  logic [7:0]  w_op_exp;
  logic [6:0]  w_op_frac;
  logic [3:0]  w_class;
  logic [7:0]  w_ext_exp;
  logic [7:0]  w_ext_mant;
  logic        w_wd_expired;
  logic        w_bypass;
  logic [15:0] w_byp_res;

  assign w_op_exp     = op_i[14:7];
  assign w_op_frac    = op_i[6:0];
  assign w_class      = classify(w_op_exp, w_op_frac);
  assign w_wd_expired = (r_wd == WD_LAST);

  // Unpack: denormals get exponent 1 and no hidden bit; zero unpacks to all zeros.
  always_comb begin
    w_ext_exp  = w_op_exp;
    w_ext_mant = {1'b1, w_op_frac};
    if (w_op_exp == 8'h00) begin
      w_ext_exp  = {7'd0, (w_op_frac != 7'h00)};
      w_ext_mant = {1'b0, w_op_frac};
    end else begin
      w_ext_exp  = w_op_exp;
      w_ext_mant = {1'b1, w_op_frac};
    end
  end

`ifdef LAMP_SQRT_ISSUE_BYPASS_EN
  // Local resolution of special operands; w_class = {zero, inf, snan, qnan}.
  always_comb begin
    w_bypass  = 1'b1;
    w_byp_res = QNAN_RES;
    if (w_class[1] || w_class[0]) begin
      w_byp_res = QNAN_RES;
    end else if (op_i[15] && !w_class[3]) begin
      w_byp_res = QNAN_RES;
    end else if (w_class[3]) begin
      // sqrt(+-0) = +-0, 1/sqrt(+-0) = +-inf
      w_byp_res = op_inv_i ? {op_i[15], 15'h7F80} : {op_i[15], 15'h0000};
    end else if (w_class[2]) begin
      w_byp_res = op_inv_i ? 16'h0000 : 16'h7F80;
    end else begin
      w_bypass  = 1'b0;
      w_byp_res = 16'h0000;
    end
  end
`else
  // No local resolution: every operand goes to the core.
  always_comb begin
    w_bypass  = 1'b0;
    w_byp_res = 16'h0000;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a core result beats a coincident watchdog expiry.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (op_valid_i) begin
          w_state_nxt = w_bypass ? ST_RESP : ST_CORE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CORE: begin
        if (valid_i || w_wd_expired) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_CORE;
        end
      end
      ST_RESP: begin
        if (res_ready_i) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture, watchdog and result registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wd       <= 8'd0;
      r_inv      <= 1'b0;
      r_sign     <= 1'b0;
      r_ext_exp  <= 8'd0;
      r_ext_mant <= 8'd0;
      r_class    <= 4'd0;
      r_res      <= 16'h0000;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (op_valid_i) begin
            r_wd       <= 8'd0;
            r_inv      <= op_inv_i;
            r_sign     <= op_i[15];
            r_ext_exp  <= w_ext_exp;
            r_ext_mant <= w_ext_mant;
            r_class    <= w_class;
            if (w_bypass) begin
              r_res <= w_byp_res;
              r_err <= 1'b0;
            end
          end
        end
        ST_CORE: begin
          if (valid_i) begin
            r_res <= {s_res_i, e_res_i, f_res_i};
            r_err <= 1'b0;
          end else if (w_wd_expired) begin
            r_res <= QNAN_RES;
            r_err <= 1'b1;
          end else begin
            r_wd <= r_wd + 8'd1;
          end
        end
        ST_RESP: begin
          r_res <= r_res;
        end
        default: begin
          r_wd <= 8'd0;
        end
      endcase
    end
  end

  // Handshake and core-start outputs decoded from the state register.
  always_comb begin
    op_ready_o  = 1'b0;
    doSqrt_o    = 1'b0;
    res_valid_o = 1'b0;
    busy_o      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        op_ready_o = 1'b1;
        busy_o     = 1'b0;
      end
      ST_CORE: doSqrt_o    = 1'b1;
      ST_RESP: res_valid_o = 1'b1;
      default: busy_o      = 1'b1;
    endcase
  end

  assign invSqrt_o    = r_inv;
  assign signum_op_o  = r_sign;
  assign extExp_op_o  = r_ext_exp;
  assign extMant_op_o = r_ext_mant;
  assign isZero_op_o  = r_class[3];
  assign isInf_op_o   = r_class[2];
  assign isSNAN_op_o  = r_class[1];
  assign isQNAN_op_o  = r_class[0];
  assign res_o        = r_res;
  assign res_err_o    = r_err;

endmodule

// File: tb/tb_lampfpu_sqrt_issue.sv
module tb_lampfpu_sqrt_issue;

`ifdef LAMP_SQRT_ISSUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid_i;
  logic        op_ready_o;
  logic [15:0] op_i;
  logic        op_inv_i;
  logic        doSqrt_o;
  logic        invSqrt_o;
  logic        signum_op_o;
  logic [7:0]  extExp_op_o;
  logic [7:0]  extMant_op_o;
  logic        isZero_op_o;
  logic        isInf_op_o;
  logic        isSNAN_op_o;
  logic        isQNAN_op_o;
  logic        valid_i;
  logic        s_res_i;
  logic [7:0]  e_res_i;
  logic [6:0]  f_res_i;
  logic        res_valid_o;
  logic        res_ready_i;
  logic [15:0] res_o;
  logic        res_err_o;
  logic        busy_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lampfpu_sqrt_issue #(.TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst),
    .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
    .op_i(op_i), .op_inv_i(op_inv_i),
    .doSqrt_o(doSqrt_o), .invSqrt_o(invSqrt_o),
    .signum_op_o(signum_op_o), .extExp_op_o(extExp_op_o), .extMant_op_o(extMant_op_o),
    .isZero_op_o(isZero_op_o), .isInf_op_o(isInf_op_o),
    .isSNAN_op_o(isSNAN_op_o), .isQNAN_op_o(isQNAN_op_o),
    .valid_i(valid_i), .s_res_i(s_res_i), .e_res_i(e_res_i), .f_res_i(f_res_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_o(res_o), .res_err_o(res_err_o), .busy_o(busy_o)
  );

  typedef struct {
    logic [15:0] op;
    logic        inv;
    logic [7:0]  x_exp;
    logic [7:0]  x_mant;
    logic [3:0]  x_flags;   // {zero, inf, snan, qnan}
    logic        special;   // resolved locally when the bypass is built in
    logic [15:0] byp_res;
    int          lat;       // core responds in this doSqrt cycle; 0 = never
    logic [15:0] core_res;
    logic [15:0] x_res;
    logic        x_err;
    int          x_cyc;     // expected cycles with doSqrt_o high
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " op_ready"},  {31'd0, op_ready_o}, 32'd1);
    chk({tag, " busy"},      {31'd0, busy_o}, 32'd0);
    chk({tag, " res_valid"}, {31'd0, res_valid_o}, 32'd0);
    chk({tag, " res"},       {16'd0, res_o}, 32'h0000);
    chk({tag, " res_err"},   {31'd0, res_err_o}, 32'd0);
    chk({tag, " core side"},
        {8'd0, doSqrt_o, invSqrt_o, signum_op_o, extExp_op_o, extMant_op_o,
         isZero_op_o, isInf_op_o, isSNAN_op_o, isQNAN_op_o}, 32'd0);
  endtask

  task automatic handshake();
    res_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready_i = 1'b0;
    chk("back to idle", {30'd0, op_ready_o, busy_o}, 32'd2);
  endtask

  // Drives one request from a negedge and checks it through to the response.
  task automatic run_vec(input vec_t v, input int idx);
    int cnt;
    string tg;
    tg = $sformatf("v%0d", idx);
    chk({tg, " ready before accept"}, {31'd0, op_ready_o}, 32'd1);
    op_valid_i = 1'b1;
    op_i       = v.op;
    op_inv_i   = v.inv;
    @(posedge clk);
    @(negedge clk);
    op_valid_i = 1'b0;
    if (BYP && v.special) begin
      chk({tg, " byp res_valid cyc1"}, {31'd0, res_valid_o}, 32'd1);
      chk({tg, " byp doSqrt"},         {31'd0, doSqrt_o}, 32'd0);
      chk({tg, " byp res"},            {16'd0, res_o}, {16'd0, v.byp_res});
      chk({tg, " byp err"},            {31'd0, res_err_o}, 32'd0);
    end else begin
      chk({tg, " doSqrt cyc1"}, {31'd0, doSqrt_o}, 32'd1);
      chk({tg, " operand"},
          {14'd0, signum_op_o, invSqrt_o, extExp_op_o, extMant_op_o},
          {14'd0, v.op[15], v.inv, v.x_exp, v.x_mant});
      chk({tg, " flags"}, {28'd0, isZero_op_o, isInf_op_o, isSNAN_op_o, isQNAN_op_o},
          {28'd0, v.x_flags});
      cnt = 0;
      while (doSqrt_o === 1'b1 && cnt < 300) begin
        cnt++;
        if (cnt == v.lat) begin
          valid_i = 1'b1;
          {s_res_i, e_res_i, f_res_i} = v.core_res;
        end
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
      end
      chk({tg, " doSqrt cycles"}, cnt, v.x_cyc);
      chk({tg, " res_valid"}, {31'd0, res_valid_o}, 32'd1);
      chk({tg, " res"},       {16'd0, res_o}, {16'd0, v.x_res});
      chk({tg, " err"},       {31'd0, res_err_o}, {31'd0, v.x_err});
    end
    handshake();
  endtask

  initial begin
    //          op       inv   exp    mant   flags  sp    byp_res  lat core_res x_res   err  cyc
    vecs[0]  = '{16'h4080, 1'b0, 8'h81, 8'h80, 4'h0, 1'b0, 16'h0000, 5, 16'h4000, 16'h4000, 1'b0, 5};
    vecs[1]  = '{16'h0001, 1'b1, 8'h01, 8'h01, 4'h0, 1'b0, 16'h0000, 3, 16'h5F00, 16'h5F00, 1'b0, 3};
    vecs[2]  = '{16'hC080, 1'b0, 8'h81, 8'h80, 4'h0, 1'b1, 16'h7FC0, 2, 16'h7FC0, 16'h7FC0, 1'b0, 2};
    vecs[3]  = '{16'h0000, 1'b1, 8'h00, 8'h00, 4'h8, 1'b1, 16'h7F80, 1, 16'h7F80, 16'h7F80, 1'b0, 1};
    vecs[4]  = '{16'h7F81, 1'b0, 8'hFF, 8'h81, 4'h2, 1'b1, 16'h7FC0, 4, 16'h7FC0, 16'h7FC0, 1'b0, 4};
    vecs[5]  = '{16'h7FC0, 1'b1, 8'hFF, 8'hC0, 4'h1, 1'b1, 16'h7FC0, 2, 16'h7FC0, 16'h7FC0, 1'b0, 2};
    vecs[6]  = '{16'h7F80, 1'b1, 8'hFF, 8'h80, 4'h4, 1'b1, 16'h0000, 2, 16'h0000, 16'h0000, 1'b0, 2};
    vecs[7]  = '{16'h8000, 1'b0, 8'h00, 8'h00, 4'h8, 1'b1, 16'h8000, 3, 16'h8000, 16'h8000, 1'b0, 3};
    vecs[8]  = '{16'h8000, 1'b1, 8'h00, 8'h00, 4'h8, 1'b1, 16'hFF80, 3, 16'hFF80, 16'hFF80, 1'b0, 3};
    // core never answers: watchdog abort after exactly 64 doSqrt cycles
    vecs[9]  = '{16'h3F80, 1'b1, 8'h7F, 8'h80, 4'h0, 1'b0, 16'h0000, 0, 16'h0000, 16'h7FC0, 1'b1, 64};
    // core answers in the same cycle the watchdog expires: core result wins
    vecs[10] = '{16'h4000, 1'b0, 8'h80, 8'h80, 4'h0, 1'b0, 16'h0000, 64, 16'h3FB5, 16'h3FB5, 1'b0, 64};

    rst = 1'b0; op_valid_i = 1'b0; op_i = 16'h0000; op_inv_i = 1'b0;
    valid_i = 1'b0; s_res_i = 1'b0; e_res_i = 8'h00; f_res_i = 7'h00; res_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b1;

    // valid_i outside CORE must be ignored
    valid_i = 1'b1; {s_res_i, e_res_i, f_res_i} = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    chk("idle valid ignored", {15'd0, res_valid_o, res_o}, 32'h0000_0000);

    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], i);
    end

    // Response stall: result held, new requests ignored, no accept on RESP exit.
    op_valid_i = 1'b1; op_i = 16'h4080; op_inv_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    op_i = 16'h4100;
    valid_i = 1'b1; {s_res_i, e_res_i, f_res_i} = 16'h4000;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("stall%0d", k), {14'd0, res_valid_o, op_ready_o, res_o},
          {14'd0, 1'b1, 1'b0, 16'h4000});
      @(posedge clk);
      @(negedge clk);
    end
    res_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready_i = 1'b0;
    chk("no accept on exit", {29'd0, op_ready_o, doSqrt_o, res_valid_o}, 32'd4);
    @(posedge clk);
    @(negedge clk);
    op_valid_i = 1'b0;
    chk("next op accepted", {23'd0, doSqrt_o, extExp_op_o}, {23'd0, 1'b1, 8'h82});

    // Reset in the middle of CORE.
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("mid-op reset");
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("idle after reset", {30'd0, op_ready_o, doSqrt_o}, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lampfpu_sqrt_issue.md
# lampfpu_sqrt_issue

Request-side controller for the LAMP FPU square-root / inverse-square-root core. Accepts packed 1-8-7 floats over a valid/ready handshake, unpacks and classifies them, and drives the core's `doSqrt`/`invSqrt` operand interface. It then waits for the core's `valid`, repacks the result, and returns it over a second valid/ready handshake. A watchdog guards against a core that never responds.

## Interface
- `TIMEOUT_CYC`, default 64: maximum cycles `doSqrt_o` stays high before abort; legal range 2..255.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `op_valid_i` in 1: request valid.
- `op_ready_o` out 1: request accepted when both are high.
- `op_i` in 16: packed operand {s, e[7:0], f[6:0]}.
- `op_inv_i` in 1: 1 = 1/sqrt(x), 0 = sqrt(x).
- `doSqrt_o` out 1: core start, level, held until `valid_i`.
- `invSqrt_o` out 1: core mode.
- `signum_op_o` out 1, `extExp_op_o` out 8, `extMant_op_o` out 8: unpacked operand.
- `isZero_op_o`, `isInf_op_o`, `isSNAN_op_o`, `isQNAN_op_o` out 1 each: operand class.
- `valid_i` in 1: core result valid.
- `s_res_i` in 1, `e_res_i` in 8, `f_res_i` in 7: core result fields.
- `res_valid_o` out 1, `res_ready_i` in 1: result handshake.
- `res_o` out 16: packed result {s, e, f}.
- `res_err_o` out 1: result produced by watchdog abort.
- `busy_o` out 1: state is not IDLE.

## Operation
- FSM states: IDLE, CORE, RESP.
- IDLE: `op_ready_o`=1. On accept, register unpack of `op_i`:
  - e=0, f=0: zero; extExp=0, extMant=0.
  - e=0, f≠0: denormal; extExp=1, extMant={0,f}.
  - 1≤e≤254: extExp=e, extMant={1,f}.
  - e=255, f=0: inf.
  - e=255, f[6]=1: QNAN.
  - e=255, f[6]=0, f≠0: SNAN.
- After accept, go to CORE (or RESP on bypass, see Configuration).
- CORE: `doSqrt_o`=1, and operand outputs are stable.
  - On `valid_i`: capture {s_res_i, e_res_i, f_res_i} into `res_o`, set `res_err_o`=0, go to RESP.
  - Watchdog counter increments each CORE cycle. If it reaches `TIMEOUT_CYC` with no `valid_i`: `res_o`=0x7FC0, `res_err_o`=1, go to RESP.
  - If `valid_i` and timeout coincide, `valid_i` wins.
- RESP: `res_valid_o`=1; `res_o` and `res_err_o` are held stable. On `res_ready_i`, go to IDLE.
- `valid_i` outside CORE is ignored.
- `op_i` and `op_valid_i` are ignored outside IDLE; there is no same-cycle accept on the RESP exit.

## Timing
- Reset (`rst`=0 at a clock edge): state IDLE.
  - Output reset values: `op_ready_o`=1, `busy_o`=0, `res_err_o`=0, `res_o`=0x0000, `res_valid_o`=0.
  - Core-side outputs: `doSqrt_o`=0, `invSqrt_o`=0, `signum_op_o`=0, `extExp_op_o`=0, `extMant_op_o`=0, all `is*_op_o`=0.
- Reset mid-operation aborts the operation without producing a result. The core shares `rst`.
- Accept edge = cycle 0. `doSqrt_o` rises in cycle 1.
- If `valid_i` is sampled at edge N, `res_valid_o` is high from cycle N+1 and `doSqrt_o` is low from cycle N+1.
- Bypass latency: `res_valid_o` is high in cycle 1.
- Minimum request-to-request spacing: result handshake edge + 1 cycle.
- Watchdog is cleared on each entry to CORE. An abort occurs when `doSqrt_o` has been high for `TIMEOUT_CYC` cycles.

## Configuration
- Macro: `LAMP_SQRT_ISSUE_BYPASS_EN`.
- When defined, special operands never reach the core (`doSqrt_o` stays 0). The accept goes directly to RESP with these results:
  - NaN: 0x7FC0.
  - Negative nonzero (including -inf): 0x7FC0.
  - sqrt: ±0 → ±0 (0x0000 / 0x8000); +inf → 0x7F80.
  - inv: +0 → 0x7F80; -0 → 0xFF80; +inf → 0x0000.
- When undefined, every operand is issued to the core with its class flags, and the core resolves special cases.

## Test plan
- sqrt 0x4080 (4.0); core model returns s=0, e=0x80, f=0 five cycles after `doSqrt_o` rises → `extExp_op_o`=0x81, `extMant_op_o`=0x80, `doSqrt_o` high 5 cycles, `res_o`=0x4000, `res_err_o`=0.
- Denormal 0x0001, inv=1 → `extExp_op_o`=0x01, `extMant_op_o`=0x01, `invSqrt_o`=1, all class flags 0.
- 0xC080 (-4.0), macro defined → `doSqrt_o` never rises, `res_valid_o` in cycle 1, `res_o`=0x7FC0. Macro undefined → issued with `signum_op_o`=1.
- inv of 0x0000, macro defined → `res_o`=0x7F80 in cycle 1. Also 0x7F81 → 0x7FC0.
- Core never asserts `valid_i`, `TIMEOUT_CYC`=64 → `doSqrt_o` high exactly 64 cycles, then `res_o`=0x7FC0, `res_err_o`=1.
- `res_ready_i` held low 10 cycles → `res_o` stable, `op_ready_o`=0. After the handshake, the next op is accepted one cycle later. Also assert `rst`=0 during CORE → all outputs return to reset values at the next edge.
